instr_decode_stage: RTL and testbench

Parametrised, pipelined instruction decode stage for the control unit. It accepts raw instructions over a valid/ready handshake and buffers them in a small FIFO. Each instruction is decoded into memory, processing or loop control words, and the result is held in an output register with its own valid/ready handshake. It also tracks loop nesting depth and flags illegal opcodes or bad nesting per instruction, without stalling the pipe.

---
 rtl/instr_decode_stage.sv | 145 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: FIFO-buffered instruction decoder with a registered valid/ready output.
// DECODER_LOOP_CHECK_EN enables loop depth tracking and overflow/underflow errors.
module instr_decode_stage #(
    parameter int OPC_W      = 5,
    parameter int INSTR_W    = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int LOOP_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INSTR_W-1:0]              raw_instruction,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [1:0]                      instruction_type,
    output logic [15:0]                     memory_instruction,
    output logic [15:0]                     processing_instruction,
    output logic [4:0]                      loop_instruction,
    output logic                            error,
    input  logic                            err_clear,
    output logic [OPC_W-1:0]                error_opcode,
    output logic [$clog2(LOOP_DEPTH+1)-1:0] loop_depth,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int DW = $clog2(LOOP_DEPTH+1);

    logic [INSTR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [INSTR_W-1:0] head;
    logic [OPC_W-1:0]   opc;
    logic [12:0]        p;
    logic               push, load, unused_bits;
    int unsigned        op;
    logic [15:0]        u;
    logic [3:0]         m;
    logic               d_start, d_end, d_bad, d_err;
    logic [1:0]         d_type;
    logic [15:0]        d_mem, d_proc;
    logic [4:0]         d_loop;

    assign in_ready    = fifo_count != CW'(FIFO_DEPTH);
    assign push        = in_valid && in_ready;
    assign load        = fifo_count != '0 && (!out_valid || out_ready);
    assign head        = mem[rd_ptr];
    assign opc         = head[INSTR_W-1 -: OPC_W];
    assign p           = head[12:0];
    assign unused_bits = ^head;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= raw_instruction;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(load);
        end
    end

`ifdef DECODER_LOOP_CHECK_EN
    logic [DW-1:0] depth;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) depth <= '0;
        else if (load && !d_err) depth <= depth + DW'(d_start) - DW'(d_end);
    end
    assign loop_depth = depth;
`else
    assign loop_depth = '0;
`endif

    always_comb begin
        op = 32'(opc);
        u  = '0;
        m  = '0;
        case (op)
            0:  u = 16'h8000;
            1:  u = 16'h4000;
            2:  u = 16'h2000;
            3:  begin u = 16'h2000; m = 4'b0001; end
            4:  begin u = 16'h4000; m = {p[12], 3'b000}; end
            5:  u = 16'h1000;
            6:  u = 16'h0800;
            7:  begin u = 16'h0400; m = {p[12], 3'b000}; end
            8:  begin u = 16'h0200; m = {p[12], 3'b000}; end
            9:  u = 16'h0100;
            10: u = 16'h0080;
            11: u = 16'h0040;
            12: begin u = 16'h0100; m = 4'b0010; end
            13: begin u = 16'h0020; m = p[12:9]; end
            14: begin u = 16'h0010; m = {p[12:11], 2'b00}; end
            default: ;
        endcase
        d_start = op == 17 || op == 18;
        d_end   = op == 19;
`ifdef DECODER_LOOP_CHECK_EN
        d_bad   = (d_start && depth == DW'(LOOP_DEPTH)) || (d_end && depth == '0);
`else
        d_bad   = 1'b0;
`endif
        d_type  = op < 15 ? 2'b01 : op < 17 ? 2'b00 : (op < 20 && !d_bad) ? 2'b10 : 2'b11;
        d_err   = d_type == 2'b11;
        d_proc  = d_type == 2'b01 ? (u | {12'd0, m}) : '0;
        d_mem   = op == 15 ? {2'b10, p[12:1], 2'b00} :
                  op == 16 ? {2'b11, p[12:9], 2'b00, p[6:3], 2'b00, p[8:7]} : '0;
        d_loop  = d_type == 2'b10 ? {d_end ? 2'b11 : op == 18 ? 2'b01 : 2'b00, p[12:10]} : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid              <= 1'b0;
            instruction_type       <= 2'b00;
            memory_instruction     <= '0;
            processing_instruction <= '0;
            loop_instruction       <= '0;
            error                  <= 1'b0;
            error_opcode           <= '0;
        end else begin
            if (load) begin
                out_valid              <= 1'b1;
                instruction_type       <= d_type;
                memory_instruction     <= d_mem;
                processing_instruction <= d_proc;
                loop_instruction       <= d_loop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // clear wins over an error arriving in the same cycle
            if (err_clear) begin
                error        <= 1'b0;
                error_opcode <= '0;
            end else if (load && d_err) begin
                error <= 1'b1;
                if (!error) error_opcode <= opc;
            end
        end
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed stimulus checked every cycle against a queue-based reference model.
module tb_instr_decode_stage;
    logic        clk = 0, reset = 0;
    logic        in_valid = 0, out_ready = 0, err_clear = 0;
    logic [17:0] raw_instruction = 0;
    logic        in_ready, out_valid, error;
    logic [1:0]  instruction_type;
    logic [15:0] memory_instruction, processing_instruction;
    logic [4:0]  loop_instruction, error_opcode;
    logic [1:0]  loop_depth;
    logic [2:0]  fifo_count;
    int checks = 0, errors = 0;

    instr_decode_stage #(.OPC_W(5), .INSTR_W(18), .FIFO_DEPTH(4), .LOOP_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .raw_instruction(raw_instruction), .out_valid(out_valid), .out_ready(out_ready),
        .instruction_type(instruction_type), .memory_instruction(memory_instruction),
        .processing_instruction(processing_instruction), .loop_instruction(loop_instruction),
        .error(error), .err_clear(err_clear), .error_opcode(error_opcode),
        .loop_depth(loop_depth), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [17:0] mk(input int opc, input logic [12:0] pl);
        logic [4:0] o;
        o = 5'(opc);
        return {o, pl};
    endfunction

    // reference model: spec tables applied to whole instructions
    int ubit [15] = '{15, 14, 13, 13, 14, 12, 11, 10, 9, 8, 7, 6, 8, 5, 4};
    logic [17:0] q[$];
    logic [17:0] w;
    bit          mv = 0, me = 0, ld, pu, e;
    logic [1:0]  mt = 0, t;
    logic [15:0] mm = 0, mp = 0, a, b;
    logic [4:0]  ml = 0, meo = 0, c;
    int          md = 0, nd;

    task automatic mdec(input logic [17:0] x, input int dep, output logic [1:0] ty,
                        output logic [15:0] mw, output logic [15:0] pw, output logic [4:0] lw,
                        output bit er, output int ndep);
        int op;
        logic [12:0] pl;
        logic [3:0] mode;
        bit bad;
        op = int'(x[17:13]);
        pl = x[12:0];
        ty = 2'b11; mw = 0; pw = 0; lw = 0; er = 0; ndep = dep; bad = 0;
        if (op <= 14) begin
            case (op)
                3: mode = 4'd1;
                4, 7, 8: mode = {pl[12], 3'b0};
                12: mode = 4'd2;
                13: mode = pl[12:9];
                14: mode = {pl[12:11], 2'b0};
                default: mode = 0;
            endcase
            ty = 2'b01;
            pw = (16'h1 << ubit[op]) | {12'd0, mode};
        end else if (op == 15) begin
            ty = 2'b00; mw = {2'b10, pl[12:1], 2'b00};
        end else if (op == 16) begin
            ty = 2'b00; mw = {2'b11, pl[12:9], 2'b00, pl[6:5], pl[4:3], 2'b00, pl[8:7]};
        end else if (op <= 19) begin
`ifdef DECODER_LOOP_CHECK_EN
            bad = (op < 19) ? (dep == 2) : (dep == 0);
`endif
            if (bad) er = 1;
            else begin
                ty = 2'b10;
                lw = {op == 19 ? 2'b11 : op == 18 ? 2'b01 : 2'b00, pl[12:10]};
`ifdef DECODER_LOOP_CHECK_EN
                ndep = op < 19 ? dep + 1 : dep - 1;
`endif
            end
        end else er = 1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete(); mv = 0; me = 0; meo = 0; md = 0; mt = 0; mm = 0; mp = 0; ml = 0;
        end else begin
            ld = q.size() > 0 && (!mv || out_ready);
            pu = in_valid && q.size() < 4;
            e = 0;
            if (ld) begin
                w = q.pop_front();
                mdec(w, md, t, a, b, c, e, nd);
                mv = 1; mt = t; mm = a; mp = b; ml = c; md = nd;
            end else if (out_ready) mv = 0;
            if (err_clear) begin me = 0; meo = 0; end
            else if (ld && e) begin
                if (!me) meo = w[17:13];
                me = 1;
            end
            if (pu) q.push_back(raw_instruction);
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, mv);
        chk("fifo_count", fifo_count, q.size());
        chk("in_ready", in_ready, q.size() != 4);
        chk("error", error, me);
        chk("error_opcode", error_opcode, meo);
        chk("loop_depth", loop_depth, md);
        if (mv) begin
            chk("type", instruction_type, mt);
            chk("mem", memory_instruction, mm);
            chk("proc", processing_instruction, mp);
            chk("loop", loop_instruction, ml);
        end
    end

    task automatic send(input logic [17:0] x);
        in_valid = 1;
        raw_instruction = x;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        chk("send_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_type", instruction_type, 0);
        chk("rst_proc", processing_instruction, 0);
        chk("rst_error", error, 0);
        out_ready = 1;
        send(mk(0, 0));
        chk("lat_before", out_valid, 0);
        @(negedge clk);
        chk("matmul_valid", out_valid, 1);
        chk("matmul_type", instruction_type, 2'b01);
        chk("matmul_proc", processing_instruction, 16'h8000);
        chk("matmul_mem", memory_instruction, 0);
        repeat (2) @(negedge clk);
        send(mk(15, 13'h1FFF));
        send(mk(16, 13'h0180));
        chk("load_word", memory_instruction, 16'hBFFC);
        @(negedge clk);
        chk("store_word", memory_instruction, 16'hC003);
        repeat (2) @(negedge clk);
        out_ready = 0;
        send(mk(1, 0)); send(mk(2, 0)); send(mk(3, 0));
        send(mk(4, 13'h1000)); send(mk(7, 13'h1000));
        in_valid = 1;
        raw_instruction = mk(13, 13'h1E00);
        repeat (3) @(negedge clk);
        chk("full_count", fifo_count, 4);
        chk("full_ready", in_ready, 0);
        chk("full_held", processing_instruction, 16'h4000);
        out_ready = 1;
        for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (8) @(negedge clk);
        chk("drained", fifo_count, 0);
        send(mk(25, 0));
        send(mk(30, 0));
        repeat (3) @(negedge clk);
        chk("err_set", error, 1);
        chk("err_opc", error_opcode, 25);
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        chk("err_cleared", error, 0);
        chk("err_opc_cleared", error_opcode, 0);
        send(mk(31, 0));
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        chk("clear_priority", error, 0);
        chk("clear_prio_type", instruction_type, 2'b11);
        send(mk(20, 5));
        repeat (2) @(negedge clk);
        chk("err_again", error, 1);
        chk("err_again_opc", error_opcode, 20);
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        send(mk(17, 13'h1C00));
        @(negedge clk);
        chk("sil_type", instruction_type, 2'b10);
        chk("sil_word", loop_instruction, 5'h07);
        send(mk(18, 13'h0400)); send(mk(18, 0));
        send(mk(19, 0)); send(mk(19, 0)); send(mk(19, 0));
        repeat (3) @(negedge clk);
        chk("loop_final_depth", loop_depth, 0);
`ifdef DECODER_LOOP_CHECK_EN
        chk("loop_error", error, 1);
`else
        chk("loop_error", error, 0);
`endif
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        out_ready = 0;
        send(mk(2, 0)); send(mk(5, 0)); send(mk(6, 0)); send(mk(9, 0));
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_valid", out_valid, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
